// File: rtl/peak_env_pkg.sv
// peak_env_pkg: shared widths, FSM encoding and saturating magnitude for peak_envelope_12bit.
package peak_env_pkg;
  localparam int SAMPLE_W = 12;
  localparam int MAG_W = 11;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  function automatic logic [MAG_W-1:0] abs_sat12(input logic signed [SAMPLE_W-1:0] v);
    logic [SAMPLE_W-1:0] n;
    n = v[SAMPLE_W-1] ? (~v + 1'b1) : v;
    return n[SAMPLE_W-1] ? {MAG_W{1'b1}} : n[MAG_W-1:0];
  endfunction
endpackage

// File: rtl/peak_window_acc.sv
// peak_window_acc: per-window sample counter and max-magnitude accumulator; PEAK_DECAY_EN seeds the next window with a released peak.
module peak_window_acc
  import peak_env_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int CNT_W = 16,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ready,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic                       close,
  output logic [MAG_W-1:0]           peak
);
`ifdef PEAK_DECAY_EN
  localparam bit DECAY_EN = 1'b1;
`else
  localparam bit DECAY_EN = 1'b0;
`endif
  logic [CNT_W-1:0] r_count;
  logic [MAG_W-1:0] r_acc;
  logic [MAG_W-1:0] w_mag;
  logic [MAG_W-1:0] w_release;
  assign w_mag = abs_sat12(x);
  assign peak = (w_mag > r_acc) ? w_mag : r_acc;
  assign close = ready && (r_count == CNT_W'(WINDOW - 1));
  assign w_release = DECAY_EN ? peak - (peak >> DECAY_SHIFT) : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_acc <= '0;
    end else if (close) begin
      r_count <= '0;
      r_acc <= w_release;
    end else if (ready) begin
      r_count <= r_count + 1'b1;
      r_acc <= peak;
    end
  end
endmodule

// File: rtl/peak_envelope_12bit.sv
// peak_envelope_12bit: windowed peak detector feeding a dB converter over a start/done handshake.
// Build with PEAK_DECAY_EN for peak-hold with release between windows.
module peak_envelope_12bit
  import peak_env_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int CNT_W = 16,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ready,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic                       db_start,
  output logic signed [SAMPLE_W-1:0] db_value,
  input  logic                       db_done,
  output logic [MAG_W-1:0]           peak_out,
  output logic                       window_tick,
  output logic                       overrun
);
  logic                       w_close;
  logic [MAG_W-1:0]           w_peak;
  logic [MAG_W-1:0]           r_pend;
  logic                       r_pending_valid;
  logic                       w_consume;
  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_db_start;
  logic                       w_start_nxt;
  logic signed [SAMPLE_W-1:0] r_db_value;
  logic signed [SAMPLE_W-1:0] w_value_nxt;
  logic [MAG_W-1:0]           r_peak_out;
  logic                       r_window_tick;
  logic                       r_overrun;
  peak_window_acc #(.WINDOW(WINDOW), .CNT_W(CNT_W), .DECAY_SHIFT(DECAY_SHIFT)) u_acc (
    .clock(clock),
    .reset(reset),
    .ready(ready),
    .x(x),
    .close(w_close),
    .peak(w_peak)
  );
  assign w_consume = (r_state == ST_IDLE) && r_pending_valid;
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = w_consume;
    w_value_nxt = w_consume ? {1'b0, r_pend} : r_db_value;
    if (w_consume) w_state_nxt = ST_BUSY;
    else if (r_state == ST_BUSY && db_done) w_state_nxt = ST_IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_db_start <= 1'b0;
      r_db_value <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_db_start <= w_start_nxt;
      r_db_value <= w_value_nxt;
    end
  end
  // A close on the consume edge refills pend after the FSM has latched the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_pending_valid <= 1'b0;
      r_peak_out <= '0;
      r_window_tick <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_window_tick <= w_close;
      if (w_close) begin
        r_pend <= w_peak;
        r_pending_valid <= 1'b1;
        r_peak_out <= w_peak;
        if (r_pending_valid && !w_consume) r_overrun <= 1'b1;
      end else if (w_consume) begin
        r_pending_valid <= 1'b0;
      end
    end
  end
  assign db_start = r_db_start;
  assign db_value = r_db_value;
  assign peak_out = r_peak_out;
  assign window_tick = r_window_tick;
  assign overrun = r_overrun;
endmodule

// File: tb/tb_peak_envelope_12bit.sv
// tb_peak_envelope_12bit: table of 4-sample windows plus handshake corner sequences, scoreboarded on db_start.
module tb_peak_envelope_12bit;
`ifdef PEAK_DECAY_EN
  localparam bit DECAY_EN = 1'b1;
`else
  localparam bit DECAY_EN = 1'b0;
`endif
  logic clock;
  logic reset;
  logic ready;
  logic signed [11:0] x;
  logic db_start;
  logic signed [11:0] db_value;
  logic db_done;
  logic [10:0] peak_out;
  logic window_tick;
  logic overrun;
  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_tick = 0;
  int carry = 0;
  int sb[$];
  typedef struct {
    int a;
    int b;
    int c;
    int d;
    int pk;
  } vec_t;
  vec_t tbl[6];

  peak_envelope_12bit #(.WINDOW(4), .CNT_W(16), .DECAY_SHIFT(3)) dut (
    .clock(clock),
    .reset(reset),
    .ready(ready),
    .x(x),
    .db_start(db_start),
    .db_value(db_value),
    .db_done(db_done),
    .peak_out(peak_out),
    .window_tick(window_tick),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic put(input int v);
    ready = 1'b1;
    x = 12'(v);
    @(posedge clock);
    #1;
    ready = 1'b0;
    x = '0;
  endtask

  task automatic done_pulse();
    db_done = 1'b1;
    cycles(1);
    db_done = 1'b0;
  endtask

  // Expected peak includes whatever the previous window released into the accumulator.
  task automatic win(input int a, input int b, input int c, input int d, input int pk,
                     input bit push_it, input bit done_last);
    int e;
    e = (pk > carry) ? pk : carry;
    carry = DECAY_EN ? e - (e >> 3) : 0;
    if (push_it) sb.push_back(e);
    put(a);
    put(b);
    put(c);
    ready = 1'b1;
    x = 12'(d);
    db_done = done_last;
    @(posedge clock);
    #1;
    ready = 1'b0;
    x = '0;
    db_done = 1'b0;
    chk("peak_out", int'(peak_out), e);
    chk("window_tick_high", int'(window_tick), 1);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (db_start) begin
        n_start++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got db_value=%0d, required no start", db_value);
        end else begin
          chk("db_value", int'(db_value), sb.pop_front());
        end
      end
      if (window_tick) n_tick++;
    end
  end

  initial begin
    int n0;
    tbl[0] = '{5, -300, 12, 7, 300};
    tbl[1] = '{0, -2048, 0, 0, 2047};
    tbl[2] = '{2047, -1, 0, 3, 2047};
    tbl[3] = '{-1, 1, -1, 0, 1};
    tbl[4] = '{100, -101, 99, 0, 101};
    tbl[5] = '{0, 0, 0, 0, 0};
    reset = 1'b1;
    ready = 1'b0;
    x = '0;
    db_done = 1'b0;
    cycles(3);
    chk("rst_db_start", int'(db_start), 0);
    chk("rst_db_value", int'(db_value), 0);
    chk("rst_peak_out", int'(peak_out), 0);
    chk("rst_window_tick", int'(window_tick), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    cycles(1);
    for (int i = 0; i < 6; i++) begin
      win(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].pk, 1'b1, 1'b0);
      chk("start_at_E0", int'(db_start), 0);
      cycles(1);
      chk("start_after_E1", int'(db_start), 1);
      chk("window_tick_low", int'(window_tick), 0);
      cycles(1);
      chk("start_one_cycle", int'(db_start), 0);
      done_pulse();
    end
    chk("tick_count", n_tick, 6);
    // Converter stalled across three windows: middle peak is lost.
    win(10, 0, 0, 0, 10, 1'b1, 1'b0);
    cycles(2);
    win(0, 20, 0, 0, 20, 1'b0, 1'b0);
    chk("no_overrun_yet", int'(overrun), 0);
    win(0, 0, 30, 0, 30, 1'b1, 1'b0);
    chk("overrun_set", int'(overrun), 1);
    done_pulse();
    cycles(3);
    chk("stall_drained", sb.size(), 0);
    done_pulse();
    // Async reset while BUSY with a pending peak.
    win(0, 0, 0, 40, 40, 1'b1, 1'b0);
    cycles(2);
    win(50, 0, 0, 0, 50, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_db_start", int'(db_start), 0);
    chk("arst_db_value", int'(db_value), 0);
    chk("arst_peak_out", int'(peak_out), 0);
    chk("arst_window_tick", int'(window_tick), 0);
    chk("arst_overrun", int'(overrun), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    carry = 0;
    n0 = n_start;
    put(70);
    put(0);
    put(0);
    cycles(3);
    chk("no_start_partial_window", n_start, n0);
    sb.push_back(70);
    carry = DECAY_EN ? 70 - (70 >> 3) : 0;
    put(0);
    chk("post_reset_peak_out", int'(peak_out), 70);
    cycles(2);
    chk("post_reset_start", n_start, n0 + 1);
    done_pulse();
    // db_done on the same edge as a window close.
    win(50, 0, 0, 0, 50, 1'b1, 1'b0);
    cycles(2);
    n0 = n_start;
    win(0, 60, 0, 0, 60, 1'b1, 1'b1);
    cycles(4);
    chk("single_start", n_start, n0 + 1);
    chk("no_overrun_on_done_close", int'(overrun), 0);
    done_pulse();
    // Release behaviour: loud window then silence.
    win(1024, 0, 0, 0, 1024, 1'b1, 1'b0);
    cycles(2);
    done_pulse();
    win(0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk("decay_peak", int'(peak_out), DECAY_EN ? 896 : 0);
    cycles(2);
    done_pulse();
    cycles(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
